uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Bus-mapped UART transmitter with a small transmit FIFO; drives the serial line that
//  feeds the uart_rx peripheral (or an external receiver).
//  The CPU pushes bytes over the peripheral bus.
//  Each frame is: start bit, 8 data bits LSB first, even-parity bit, stop bit.
//  This frame format matches what uart_rx expects.
// PARAMETERS
//  SPEED       86  bit period is SPEED+1 clk_i cycles (same meaning as in uart_rx)
//  FIFO_DEPTH  4   transmit FIFO entries; power of two, >=2
// PORTS
//  clk_i        in   1   system clock; single clock domain
//  rst_i        in   1   reset, asynchronous, active-high
//  addr_i       in   32  register byte address
//  uart_req_i   in   1   bus request
//  uart_we_i    in   1   1=write, 0=read
//  uart_data_i  in   32  write data; only [7:0] used
//  uart_data_o  out  32  read data, combinational
//  tx_o         out  1   serial line, registered, idles high
// BEHAVIOUR
//  Register map:
//   0x00 W: push uart_data_i[7:0] into the FIFO.
//   0x00 R: last byte accepted by a push.
//   0x04 R: {31'b0, full}.
//   0x08 R: {31'b0, busy}; busy = FSM not IDLE or FIFO not empty.
//   0x0C R: {29'b0, count}; count is 0..FIFO_DEPTH, zero-extended.
//   0x10 R: {31'b0, parity bit of the current/last frame}.
//  Writes to any address other than 0x00 are ignored.
//  Reads from unmapped addresses return 0.
//  uart_data_o = 0 whenever not (uart_req_i & !uart_we_i).
//  Reset: all of the following apply immediately, including mid-frame (the frame is cut short):
//   tx_o=1, FSM=IDLE, FIFO empty, count=0, last byte=0, parity=0, bit/baud counters=0.
//  Push:
//   - Accepted at the clock edge where uart_req_i & uart_we_i & addr_i==0 & !full.
//   - When full, the push is dropped silently, even if a pop occurs in the same cycle.
//  Pop: only in IDLE while FIFO is non-empty.
//   - The head byte is loaded into the shift register.
//   - parity = ^byte (even parity).
//   - The FSM moves to START.
//   - Push and pop in the same cycle: count unchanged, both take effect.
//  FIFO: read/write pointers wrap modulo FIFO_DEPTH.
//   full = (count==FIFO_DEPTH); empty = (count==0).
//  FSM states and transitions:
//   - IDLE: tx_o=1; pops when FIFO non-empty.
//   - START, DATA, PARITY, STOP: each bit lasts SPEED+1 cycles.
//     The baud counter runs 0..SPEED and then clears.
//   - START: tx_o=0.
//   - DATA: tx_o=shift[0]; the register shifts right at each bit end.
//     A 3-bit index runs 0..7; after index 7 the FSM goes to PARITY.
//   - PARITY: tx_o=parity.
//   - STOP: tx_o=1; at bit end the FSM returns to IDLE.
//  Latency:
//   - A write at edge N into an empty FIFO while IDLE: pop at edge N+1, tx_o=0 from edge N+2.
//   - Frame = 11*(SPEED+1) cycles.
//   - Back-to-back frames: exactly 1 IDLE cycle of tx_o=1 between STOP end and the next START.
//  Bus inputs never disturb a frame in flight. Reads have no side effects.
// TESTING
//  1. SPEED=4, write 0xA5 while idle -> tx_o:
//     0 | 1,0,1,0,0,1,0,1 | parity 0 | 1, each level held 5 cycles; START begins 2 edges after the write.
//  2. SPEED=4, write 0x07 -> parity bit 1; reg 0x10 reads 1; busy reads 1 during the frame, 0 after STOP + 1 cycle.
//  3. FIFO_DEPTH=4, six writes on consecutive cycles while idle (0x11..0x16):
//     0x11..0x15 are sent in order, 0x16 is dropped; 0x04 reads 1 after the 5th write; 0x0C reads 4.
//  4. Assert rst_i mid-DATA of a 0x3C frame with 2 more bytes queued:
//     tx_o=1 in the same cycle, count=0, busy=0; no further frames are sent after release.
//  5. Loopback tx_o->uart_rx.rx_i, both SPEED=86, send 0x00, 0xFF, 0x5A, 0x81:
//     uart_rx data reads back each byte, valid is set, parity_bit matches ^byte.
//  6. Write to 0x04 and 0x08; read 0x14; read with uart_req_i=0:
//     no push occurs (count stays 0), and all reads return 0x0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Bus-mapped UART transmitter: small byte FIFO feeding an 8E1 serial framer
// (start, 8 data LSB first, even parity, stop).
module uart_tx_fifo #(
  parameter int unsigned SPEED      = 86,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        uart_req_i,
  input  logic        uart_we_i,
  input  logic [31:0] uart_data_i,
  output logic [31:0] uart_data_o,
  output logic        tx_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = (SPEED > 0) ? $clog2(SPEED + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            tx_q, tx_d;
  logic [7:0]      last_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            full, busy, push, pop, bit_end;
  logic [7:0]      head;
  logic            unused_data;

  assign unused_data = ^uart_data_i[31:8];

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign busy    = (state_q != S_IDLE) || (count_q != '0);
  assign push    = uart_req_i && uart_we_i && (addr_i == 32'h0) && !full;
  assign pop     = (state_q == S_IDLE) && (count_q != '0);
  assign head    = mem_q[rd_ptr_q];
  assign bit_end = (baud_q == BW'(SPEED));
  assign tx_o    = tx_q;

  // FIFO storage carries no reset; validity is tracked by count_q
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= uart_data_i[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        last_q   <= uart_data_i[7:0];
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  // Line level is derived from the current state and registered one cycle later
  always_comb begin
    state_d  = state_q;
    baud_d   = bit_end ? '0 : baud_q + BW'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = 1'b1;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (pop) begin
          shift_d  = head;
          parity_d = ^head;
          idx_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        tx_d = parity_q;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  always_comb begin
    uart_data_o = 32'h0;
    if (uart_req_i && !uart_we_i) begin
      case (addr_i)
        32'h00:  uart_data_o = {24'h0, last_q};
        32'h04:  uart_data_o = {31'h0, full};
        32'h08:  uart_data_o = {31'h0, busy};
        32'h0C:  uart_data_o = 32'(count_q);
        32'h10:  uart_data_o = {31'h0, parity_q};
        default: uart_data_o = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: bus register checks plus a mid-bit sampling
// receiver that decodes every frame seen on tx_o.
module tb_uart_tx_fifo;

  localparam int SPEED = 4;
  localparam int P     = SPEED + 1;
  localparam int FD    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        tx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] rx_byte_q[$];
  logic       rx_par_q[$];
  logic       rx_err_q[$];
  int         start_q[$];
  logic [10:0] m_bits;
  logic        m_abort;

  uart_tx_fifo #(.SPEED(SPEED), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .uart_req_i(req), .uart_we_i(we),
    .uart_data_i(wdata), .uart_data_o(rdata), .tx_o(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver: samples the middle of each bit, abandons a frame on reset
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        start_q.push_back(cyc);
        m_abort = 1'b0;
        m_bits  = '1;
        for (int t = 0; t < 11 * P; t++) begin
          if (t > 0) @(negedge clk);
          if (rst) begin
            m_abort = 1'b1;
            break;
          end
          if (t % P == P / 2) m_bits[t / P] = tx;
        end
        if (m_abort) wait (!rst);
        else begin
          rx_byte_q.push_back(m_bits[8:1]);
          rx_par_q.push_back(m_bits[9]);
          rx_err_q.push_back(m_bits[0] !== 1'b0 || m_bits[10] !== 1'b1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    #1;
    d = rdata;
    req = 1'b0; addr = '0;
  endtask

  task automatic clear_rx();
    rx_byte_q.delete();
    rx_par_q.delete();
    rx_err_q.delete();
    start_q.delete();
  endtask

  task automatic wait_idle(input int limit);
    logic [31:0] d;
    int k;
    k = 0;
    do begin
      bus_read(32'h08, d);
      k++;
    end while (d !== 32'h0 && k < limit);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL wait_idle busy=%0h after %0d reads, required 0", d, k);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] exp_z;
    exp_z = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b required 1", tx); end
    for (int i = 0; i < 5; i++) begin
      bus_read(32'(i * 4), d);
      checks++;
      if (d !== exp_z) begin
        errors++;
        $display("FAIL reset_reg%0h got %0h required 0", i * 4, d);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL idle_tx got %b required 1", tx); end
  endtask

  task automatic test_frame_a5();
    logic [10:0] frm;
    int n;
    logic found;
    clear_rx();
    frm = {1'b1, 1'b0, 8'hA5, 1'b0};
    bus_write(32'h0, 32'hA5);
    n = 0;
    found = 1'b0;
    while (n < 20 && !found) begin
      @(negedge clk);
      n++;
      if (tx === 1'b0) found = 1'b1;
    end
    checks++;
    if (!found || n != 3) begin
      errors++;
      $display("FAIL a5_latency start seen at sample %0d (found=%b) required 3", n, found);
    end
    for (int t = 0; t < 11 * P; t++) begin
      if (t > 0) @(negedge clk);
      checks++;
      if (tx !== frm[t / P]) begin
        errors++;
        $display("FAIL a5_bit%0d cycle%0d got %b required %b", t / P, t % P, tx, frm[t / P]);
      end
    end
    wait_idle(200);
    checks++;
    if (rx_byte_q.size() != 1 || rx_byte_q[0] !== 8'hA5 || rx_par_q[0] !== 1'b0 || rx_err_q[0] !== 1'b0) begin
      errors++;
      $display("FAIL a5_decode frames=%0d, required one 0xA5 frame with parity 0", rx_byte_q.size());
    end
  endtask

  task automatic test_parity_busy();
    logic [31:0] d;
    clear_rx();
    bus_write(32'h0, 32'h07);
    repeat (2) @(negedge clk);
    bus_read(32'h08, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL busy_during got %0h required 1", d); end
    bus_read(32'h10, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL parity_reg got %0h required 1", d); end
    repeat (51) @(negedge clk);
    bus_read(32'h08, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL busy_last_stop got %0h required 1", d); end
    bus_read(32'h08, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL busy_after got %0h required 0", d); end
    bus_read(32'h00, d);
    checks++;
    if (d !== 32'h07) begin errors++; $display("FAIL last_byte got %0h required 07", d); end
    repeat (2) @(negedge clk);
    checks++;
    if (rx_byte_q.size() != 1 || rx_byte_q[0] !== 8'h07 || rx_par_q[0] !== 1'b1) begin
      errors++;
      $display("FAIL x07_decode frames=%0d, required 0x07 with parity 1", rx_byte_q.size());
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] d;
    logic [7:0]  exp_b [5];
    clear_rx();
    exp_b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    for (int i = 0; i < 5; i++) bus_write(32'h0, 32'(8'h11 + i));
    bus_read(32'h04, d);
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL full_after5 got %0h required 1", d); end
    bus_read(32'h0C, d);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL count_after5 got %0h required 4", d); end
    bus_write(32'h0, 32'h16);
    bus_read(32'h0C, d);
    checks++;
    if (d !== 32'h4) begin errors++; $display("FAIL count_after6 got %0h required 4", d); end
    bus_read(32'h00, d);
    checks++;
    if (d !== 32'h15) begin errors++; $display("FAIL last_after_drop got %0h required 15", d); end
    wait_idle(1000);
    checks++;
    if (rx_byte_q.size() != 5) begin
      errors++;
      $display("FAIL fifo_frames got %0d required 5", rx_byte_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_byte_q[i] !== exp_b[i] || rx_err_q[i] !== 1'b0) begin
          errors++;
          $display("FAIL fifo_byte%0d got %0h required %0h", i, rx_byte_q[i], exp_b[i]);
        end
      end
      for (int i = 1; i < 5; i++) begin
        checks++;
        if (start_q[i] - start_q[i - 1] != 11 * P + 1) begin
          errors++;
          $display("FAIL fifo_gap%0d got %0d required %0d", i, start_q[i] - start_q[i - 1], 11 * P + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] d;
    clear_rx();
    bus_write(32'h0, 32'h3C);
    bus_write(32'h0, 32'h01);
    bus_write(32'h0, 32'h02);
    repeat (10) @(negedge clk);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL mid_data_tx got %b required 0", tx); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx got %b required 1", tx); end
    bus_read(32'h0C, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_count got %0h required 0", d); end
    bus_read(32'h08, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL rst_busy got %0h required 0", d); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    clear_rx();
    repeat (150) @(negedge clk);
    checks++;
    if (start_q.size() != 0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL rst_no_frames got %0d starts tx=%b required 0 starts tx=1", start_q.size(), tx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    logic       exp_p [4];
    clear_rx();
    exp_b = '{8'h00, 8'hFF, 8'h5A, 8'h81};
    exp_p = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) bus_write(32'h0, 32'(exp_b[i]));
    wait_idle(1000);
    checks++;
    if (rx_byte_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_frames got %0d required 4", rx_byte_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_byte_q[i] !== exp_b[i] || rx_par_q[i] !== exp_p[i] || rx_err_q[i] !== 1'b0) begin
          errors++;
          $display("FAIL b2b_byte%0d got %0h par %b err %b required %0h par %b err 0",
                   i, rx_byte_q[i], rx_par_q[i], rx_err_q[i], exp_b[i], exp_p[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (start_q[i] - start_q[i - 1] != 11 * P + 1) begin
          errors++;
          $display("FAIL b2b_gap%0d got %0d required %0d", i, start_q[i] - start_q[i - 1], 11 * P + 1);
        end
      end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    clear_rx();
    bus_write(32'h04, 32'h55);
    bus_write(32'h08, 32'h66);
    bus_read(32'h0C, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL unmapped_count got %0h required 0", d); end
    bus_read(32'h14, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL read_14 got %0h required 0", d); end
    bus_read(32'h00, d);
    checks++;
    if (d !== 32'h81) begin errors++; $display("FAIL last_kept got %0h required 81", d); end
    @(negedge clk);
    req = 1'b0; we = 1'b0; addr = 32'h0;
    #1;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL no_req_read got %0h required 0", rdata); end
    req = 1'b1; we = 1'b1; addr = 32'h0C;
    #1;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL write_cycle_read got %0h required 0", rdata); end
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; addr = '0;
    repeat (20) @(negedge clk);
    checks++;
    if (start_q.size() != 0) begin
      errors++;
      $display("FAIL unmapped_frames got %0d required 0", start_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_parity_busy();
    test_fifo_full();
    test_reset_mid_frame();
    test_back_to_back();
    test_unmapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
